xor_correlator_engine: RTL
==========================

# xor_correlator_engine

Parametrised successor to the fixed 16-lane correlator core. It scores a current binary frame tile against a previous tile over a vertical search window of ±MAX_SHIFT rows, using XOR plus popcount (Hamming distance) summed over rows and enabled lanes, and reports the lowest-scoring row offset. It sits between the frame BRAM banks (dual-port read) and the PLB slave register file that starts it and collects results.

## Interface

Parameters:
- NUM_LANES, 16, BRAM banks read in parallel; one word per lane per row
- LANE_WIDTH, 128, bits per lane word
- BRAM_ADDR_WIDTH, 9, row address width
- NUM_ROWS, 32, rows per tile
- MAX_SHIFT, 4, search range; candidates dy = -MAX_SHIFT..+MAX_SHIFT
- READ_LATENCY, 1, BRAM address-to-data cycles (1 or 2)
- SCORE_WIDTH, 24, score width; must hold NUM_LANES*LANE_WIDTH*(NUM_ROWS-2*MAX_SHIFT), otherwise elaboration error

Ports:
- Bus2IP_Clk  in  1  sole clock
- Bus2IP_Resetn  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- curr_frame_bram_offset  in  BRAM_ADDR_WIDTH  current tile base row; latched on accepted start
- prev_frame_bram_offset  in  BRAM_ADDR_WIDTH  previous tile base row; latched on accepted start
- lane_mask  in  NUM_LANES  1 = lane contributes; latched on accepted start
- curr_read_addr  out  BRAM_ADDR_WIDTH  port-A row address, all lanes
- prev_read_addr  out  BRAM_ADDR_WIDTH  port-B row address, all lanes
- curr_read_data  in  NUM_LANES*LANE_WIDTH  port-A data; lane l at bits [l*LANE_WIDTH +: LANE_WIDTH]
- prev_read_data  in  NUM_LANES*LANE_WIDTH  port-B data, same packing
- busy  out  1  high from the cycle after an accepted start until done
- score_valid  out  1  one-cycle pulse per candidate
- score_dy  out  DY_WIDTH  signed candidate offset; DY_WIDTH = clog2(MAX_SHIFT+1)+1
- score_value  out  SCORE_WIDTH  candidate score
- done  out  1  one-cycle pulse after the last candidate
- best_dy  out  DY_WIDTH  signed winning offset; held until next done
- best_score  out  SCORE_WIDTH  winning score; held until next done

## Operation

- Compared rows are r = MAX_SHIFT..NUM_ROWS-1-MAX_SHIFT, so R = NUM_ROWS-2*MAX_SHIFT rows per candidate.
- score[dy] = sum over r and enabled lanes l of popcount(curr[l][r] XOR prev[l][r+dy]).
- curr_read_addr = curr_offset + r; prev_read_addr = prev_offset + r + dy. Both are mod 2^BRAM_ADDR_WIDTH and wrap silently.
- Candidates are evaluated in ascending dy. Best is updated only on strict less-than, so ties keep the more negative dy.
- FSM states:
  - IDLE: start moves to ISSUE.
  - ISSUE: R cycles, one row address pair per cycle.
  - DRAIN: READ_LATENCY+2 cycles.
  - COMPARE: 1 cycle; emits score_valid and updates best; then goes to ISSUE with dy+1, or to DONE after +MAX_SHIFT.
  - DONE: 1 cycle; done=1 and best_* updated; then back to IDLE.
- Datapath pipeline:
  - BRAM read (READ_LATENCY).
  - Stage 1: registered per-lane XOR, masking and popcount.
  - Stage 2: registered lane adder tree.
  - Accumulator: cleared entering ISSUE, adds stage-2 output when tagged valid.
- Widths:
  - Lane popcount: clog2(LANE_WIDTH+1).
  - Tree sum: clog2(NUM_LANES*LANE_WIDTH+1).
  - Accumulator: SCORE_WIDTH; no saturation is needed.
- start while busy is ignored, with no queuing. Offset and mask changes while busy have no effect.
- Reset values: every output 0, FSM in IDLE, pipeline valid tags cleared.
  - Reset mid-run aborts the run: no done and no score_valid until a new start. best_* return to 0.

## Timing

- Start accepted at edge k: busy and the first ISSUE address appear in cycle k+1.
- Each candidate takes R+READ_LATENCY+3 cycles.
- done is high in cycle k+1+(2*MAX_SHIFT+1)*(R+READ_LATENCY+3); busy falls in the same cycle.
  - Defaults (R=24, READ_LATENCY=1): 9 candidates × 28 cycles, so done at k+253.
- A new start is accepted in the first IDLE cycle after done.
- score_valid for candidate i occurs in the last cycle of that candidate's slot.

## Structure

- Shared package xor_corr_pkg holds:
  - the FSM state enumeration (IDLE, ISSUE, DRAIN, COMPARE, DONE)
  - a clog2 function
  - derived width constants for DY_WIDTH, the popcount widths and R
- Sub-module lane_popcount (parameter LANE_WIDTH): registered XOR/mask/popcount for one lane, instantiated NUM_LANES times via generate.

## Test plan

- Both tiles all-zero, defaults → 9 score_valid pulses, every score 0; best_dy=-4, best_score=0; done at k+253.
- Random non-periodic tile, prev rows = curr rows displaced so prev[r+2]=curr[r] → score(+2)=0, all others >0; best_dy=+2.
- curr all-zero, prev lane 3 all-ones, other lanes zero, lane_mask all ones → every score 3072 (128×24); best_dy=-4. Repeat with lane_mask[3]=0 → all scores 0.
- prev_offset=510 with BRAM_ADDR_WIDTH=9 → for dy=-4, first prev_read_addr=(510+4-4) mod 512=510, then wraps to 0 and upward; the bench checks the address sequence.
- start re-pulsed mid-run with different offsets → ignored; results match the first run's offsets; exactly one done.
- Bus2IP_Resetn dropped during candidate 5 → outputs 0 immediately. After release, no done until a new start; the new run completes normally.
- Sweep READ_LATENCY=2, NUM_LANES=4, LANE_WIDTH=32 → scores match the reference model; per-candidate period is R+5.

Source files
------------

// File: rtl/xor_corr_pkg.sv
// xor_corr_pkg: shared types and width helpers for the XOR correlator.
//   state_t        - control FSM states
//   clog2()        - ceiling log2, usable in constant expressions
//   dy_width() etc - derived widths as functions of the engine parameters
//   DEFAULT_*      - the derived widths for the default parameter set
package xor_corr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    COMPARE,
    DONE
  } state_t;

  function automatic int clog2(input longint value);
    int     result;
    longint span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span = span << 1;
      result++;
    end
    return result;
  endfunction

  // Signed offset must hold -max_shift..+max_shift.
  function automatic int dy_width(input int max_shift);
    return clog2(max_shift + 1) + 1;
  endfunction

  function automatic int pop_width(input int lane_width);
    return clog2(lane_width + 1);
  endfunction

  function automatic int tree_width(input int num_lanes, input int lane_width);
    return clog2(longint'(num_lanes) * lane_width + 1);
  endfunction

  function automatic int rows_compared(input int num_rows, input int max_shift);
    return num_rows - 2 * max_shift;
  endfunction

  localparam int DEFAULT_DY_WIDTH   = dy_width(4);
  localparam int DEFAULT_POP_WIDTH  = pop_width(128);
  localparam int DEFAULT_TREE_WIDTH = tree_width(16, 128);
  localparam int DEFAULT_ROWS       = rows_compared(32, 4);

endpackage

// File: rtl/xor_correlator_engine_lane_popcount.sv
// lane_popcount: one lane of stage 1. Registers popcount(curr XOR prev),
// forced to zero when the lane is disabled.
//   clk, rst_n          - clock, asynchronous active-low reset
//   enable              - lane mask bit (1 = lane contributes)
//   curr_word/prev_word - lane words from the two BRAM ports
//   count               - registered Hamming distance of the two words
module lane_popcount
  import xor_corr_pkg::*;
#(
  parameter int  LANE_WIDTH = 128,
  localparam int POP_WIDTH  = pop_width(LANE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [LANE_WIDTH-1:0] curr_word,
  input  logic [LANE_WIDTH-1:0] prev_word,
  output logic [POP_WIDTH-1:0]  count
);

  logic [LANE_WIDTH-1:0] diff;
  logic [POP_WIDTH-1:0]  count_next;

  always_comb begin
    diff       = curr_word ^ prev_word;
    count_next = '0;
    for (int i = 0; i < LANE_WIDTH; i++) begin
      count_next = count_next + POP_WIDTH'(diff[i]);
    end
    if (!enable) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/xor_correlator_engine.sv
// xor_correlator_engine: scores a current binary tile against a previous
// tile for row offsets dy = -MAX_SHIFT..+MAX_SHIFT (XOR + popcount summed
// over compared rows and enabled lanes) and reports the lowest score.
//   Bus2IP_Clk, Bus2IP_Resetn      - clock, asynchronous active-low reset
//   start                          - one-cycle request, honoured only in IDLE
//   curr/prev_frame_bram_offset    - tile base rows, latched on start
//   lane_mask                      - lane enables, latched on start
//   curr/prev_read_addr            - BRAM row addresses (all lanes share)
//   curr/prev_read_data            - BRAM data, lane l at [l*LANE_WIDTH +: LANE_WIDTH]
//   busy                           - run in progress
//   score_valid, score_dy, score_value - per-candidate result pulse
//   done, best_dy, best_score      - end-of-run pulse and held winner
module xor_correlator_engine
  import xor_corr_pkg::*;
#(
  parameter int  NUM_LANES       = 16,
  parameter int  LANE_WIDTH      = 128,
  parameter int  BRAM_ADDR_WIDTH = 9,
  parameter int  NUM_ROWS        = 32,
  parameter int  MAX_SHIFT       = 4,
  parameter int  READ_LATENCY    = 1,
  parameter int  SCORE_WIDTH     = 24,
  localparam int DY_WIDTH        = dy_width(MAX_SHIFT)
) (
  input  logic                                Bus2IP_Clk,
  input  logic                                Bus2IP_Resetn,
  input  logic                                start,
  input  logic [BRAM_ADDR_WIDTH-1:0]          curr_frame_bram_offset,
  input  logic [BRAM_ADDR_WIDTH-1:0]          prev_frame_bram_offset,
  input  logic [NUM_LANES-1:0]                lane_mask,
  output logic [BRAM_ADDR_WIDTH-1:0]          curr_read_addr,
  output logic [BRAM_ADDR_WIDTH-1:0]          prev_read_addr,
  input  logic [NUM_LANES*LANE_WIDTH-1:0]     curr_read_data,
  input  logic [NUM_LANES*LANE_WIDTH-1:0]     prev_read_data,
  output logic                                busy,
  output logic                                score_valid,
  output logic signed [DY_WIDTH-1:0]          score_dy,
  output logic [SCORE_WIDTH-1:0]              score_value,
  output logic                                done,
  output logic signed [DY_WIDTH-1:0]          best_dy,
  output logic [SCORE_WIDTH-1:0]              best_score
);

  localparam int     AW           = BRAM_ADDR_WIDTH;
  localparam int     ROWS_CMP     = rows_compared(NUM_ROWS, MAX_SHIFT);
  localparam int     POP_WIDTH    = pop_width(LANE_WIDTH);
  localparam int     TREE_WIDTH   = tree_width(NUM_LANES, LANE_WIDTH);
  localparam int     ROW_W        = clog2(ROWS_CMP + 1);
  localparam int     DRAIN_CYCLES = READ_LATENCY + 2;
  localparam int     DRAIN_W      = clog2(DRAIN_CYCLES + 1);
  localparam longint MAX_SCORE    = longint'(NUM_LANES) * LANE_WIDTH * ROWS_CMP;

  localparam logic signed [DY_WIDTH-1:0] DY_MIN = DY_WIDTH'(-MAX_SHIFT);
  localparam logic signed [DY_WIDTH-1:0] DY_MAX = DY_WIDTH'(MAX_SHIFT);

  // Parameter sanity: refuse to elaborate configurations that cannot work.
  if (MAX_SCORE >= (longint'(1) << SCORE_WIDTH)) begin : g_bad_score_width
    $error("SCORE_WIDTH too small for the worst-case score");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (ROWS_CMP < 1) begin : g_bad_rows
    $error("NUM_ROWS must exceed 2*MAX_SHIFT");
  end

  // ---------------- control state ----------------
  state_t                      state_reg, state_next;
  logic [ROW_W-1:0]            row_reg;
  logic [DRAIN_W-1:0]          drain_reg;
  logic signed [DY_WIDTH-1:0]  dy_reg;
  logic [AW-1:0]               curr_base_reg, prev_base_reg;
  logic [NUM_LANES-1:0]        mask_reg;
  logic                        issue;
  logic                        last_row;

  // ---------------- datapath state ----------------
  logic [READ_LATENCY-1:0]     issue_dly;
  logic                        s1_vld_reg, s2_vld_reg;
  logic [POP_WIDTH-1:0]        lane_cnt [NUM_LANES];
  logic [TREE_WIDTH-1:0]       tree_sum, tree_reg;
  logic [SCORE_WIDTH-1:0]      acc_reg;
  logic [SCORE_WIDTH-1:0]      run_best_score_reg;
  logic signed [DY_WIDTH-1:0]  run_best_dy_reg;
  logic [SCORE_WIDTH-1:0]      best_score_reg;
  logic signed [DY_WIDTH-1:0]  best_dy_reg;
  logic                        cand_better;
  logic [SCORE_WIDTH-1:0]      best_score_next;
  logic signed [DY_WIDTH-1:0]  best_dy_next;

  assign last_row = (row_reg == ROW_W'(ROWS_CMP - 1));

  // FSM state register.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state and control outputs.
  always_comb begin
    state_next  = state_reg;
    issue       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    score_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = ISSUE;
      end
      ISSUE: begin
        busy  = 1'b1;
        issue = 1'b1;
        if (last_row) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_reg == DRAIN_W'(DRAIN_CYCLES - 1)) state_next = COMPARE;
      end
      COMPARE: begin
        busy        = 1'b1;
        score_valid = 1'b1;
        state_next  = (dy_reg == DY_MAX) ? DONE : ISSUE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Row addresses are only driven while issuing; elsewhere they rest at 0.
  // Additions are in AW bits so offsets wrap modulo the BRAM depth.
  always_comb begin
    curr_read_addr = '0;
    prev_read_addr = '0;
    if (state_reg == ISSUE) begin
      curr_read_addr = curr_base_reg + AW'(MAX_SHIFT) + AW'(row_reg);
      prev_read_addr = prev_base_reg + AW'(MAX_SHIFT) + AW'(row_reg) + AW'(dy_reg);
    end
  end

  // Candidate winner including the score being presented this cycle.
  // The first candidate always wins; later ones only on strict less-than.
  always_comb begin
    cand_better     = (dy_reg == DY_MIN) || (acc_reg < run_best_score_reg);
    best_score_next = cand_better ? acc_reg : run_best_score_reg;
    best_dy_next    = cand_better ? dy_reg  : run_best_dy_reg;
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      row_reg            <= '0;
      drain_reg          <= '0;
      dy_reg             <= '0;
      curr_base_reg      <= '0;
      prev_base_reg      <= '0;
      mask_reg           <= '0;
      run_best_score_reg <= '0;
      run_best_dy_reg    <= '0;
      best_score_reg     <= '0;
      best_dy_reg        <= '0;
    end else begin
      row_reg   <= (state_reg == ISSUE && !last_row) ? row_reg + 1'b1 : '0;
      drain_reg <= (state_reg == DRAIN) ? drain_reg + 1'b1 : '0;
      if (state_reg == IDLE && start) begin
        curr_base_reg <= curr_frame_bram_offset;
        prev_base_reg <= prev_frame_bram_offset;
        mask_reg      <= lane_mask;
        dy_reg        <= DY_MIN;
      end
      if (state_reg == COMPARE) begin
        run_best_score_reg <= best_score_next;
        run_best_dy_reg    <= best_dy_next;
        if (state_next == ISSUE) begin
          dy_reg <= dy_reg + 1'b1;
        end else begin
          best_score_reg <= best_score_next;
          best_dy_reg    <= best_dy_next;
        end
      end
    end
  end

  // Valid tag travels alongside the BRAM read so that stage 1/2 contents
  // produced from idle-bus data are never accumulated.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      issue_dly  <= '0;
      s1_vld_reg <= 1'b0;
      s2_vld_reg <= 1'b0;
    end else begin
      issue_dly[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        issue_dly[i] <= issue_dly[i-1];
      end
      s1_vld_reg <= issue_dly[READ_LATENCY-1];
      s2_vld_reg <= s1_vld_reg;
    end
  end

  // Stage 1: per-lane XOR/mask/popcount.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lane_popcount #(
      .LANE_WIDTH (LANE_WIDTH)
    ) u_lane (
      .clk       (Bus2IP_Clk),
      .rst_n     (Bus2IP_Resetn),
      .enable    (mask_reg[gi]),
      .curr_word (curr_read_data[gi*LANE_WIDTH +: LANE_WIDTH]),
      .prev_word (prev_read_data[gi*LANE_WIDTH +: LANE_WIDTH]),
      .count     (lane_cnt[gi])
    );
  end

  // Stage 2: lane adder tree.
  always_comb begin
    tree_sum = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      tree_sum = tree_sum + TREE_WIDTH'(lane_cnt[l]);
    end
  end

  // Accumulator is cleared on every entry into ISSUE; the pipeline is empty
  // at that point because DRAIN covers the full read + stage latency.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      tree_reg <= '0;
      acc_reg  <= '0;
    end else begin
      tree_reg <= tree_sum;
      if (state_next == ISSUE && state_reg != ISSUE) begin
        acc_reg <= '0;
      end else if (s2_vld_reg) begin
        acc_reg <= acc_reg + SCORE_WIDTH'(tree_reg);
      end
    end
  end

  assign score_dy    = score_valid ? dy_reg  : '0;
  assign score_value = score_valid ? acc_reg : '0;
  assign best_dy     = best_dy_reg;
  assign best_score  = best_score_reg;

endmodule
